img_temporal_diff: RTL and testbench

Temporal-difference stage of the optical-flow pipeline, sitting directly downstream of the frame buffer that emits each pixel paired with the co-located pixel of the previous frame. Per pixel it computes the signed difference (current minus previous), saturated to CH_BITS, and passes it on alongside the current pixel for the gradient stage. Optionally it also accumulates per-frame motion statistics (thresholded motion-pixel count and absolute-difference sum), which it publishes with a one-cycle strobe at frame end.

---
 rtl/img_temporal_diff_pkg.sv | 29 ++
 rtl/img_temporal_diff_if.sv | 34 +++
 rtl/img_temporal_diff_stat.sv | 74 +++++++
 rtl/img_temporal_diff.sv | 109 ++++++++++
 tb/tb_img_temporal_diff.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_temporal_diff_pkg.sv
// Shared widths and arithmetic helpers for the temporal-difference stage.
package img_temporal_diff_pkg;

  localparam int unsigned DEF_CH_BITS    = 16;
  localparam int unsigned DEF_COUNT_BITS = 32;
  localparam int unsigned DEF_SUM_BITS   = 40;

  // Signed difference of two unsigned pixels, clamped to a signed field of 'bits'.
  function automatic longint sat_diff(input int unsigned bits, input longint cur,
                                      input longint prev);
    longint d;
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (bits - 1)) - 1;
    lo = -hi - 1;
    d  = cur - prev;
    if (d > hi)
      return hi;
    else if (d < lo)
      return lo;
    else
      return d;
  endfunction

  function automatic longint abs_diff(input longint d);
    return (d < 0) ? -d : d;
  endfunction

endpackage

// File: rtl/img_temporal_diff_if.sv
// Matrix/video stream bus: pixel data with frame sideband; m drives, s receives.
interface jelly3_mat_if #(
  parameter int unsigned TAPS      = 1,
  parameter int unsigned CH_DEPTH  = 1,
  parameter int unsigned CH_BITS   = 8,
  parameter int unsigned ROWS_BITS = 9,
  parameter int unsigned COLS_BITS = 9,
  parameter int unsigned USER_BITS = 1
) ();

  logic                                          reset;
  logic                                          clk;
  logic [ROWS_BITS-1:0]                          rows;
  logic [COLS_BITS-1:0]                          cols;
  logic                                          row_first;
  logic                                          row_last;
  logic                                          col_first;
  logic                                          col_last;
  logic [TAPS-1:0]                               de;
  logic [USER_BITS-1:0]                          user;
  logic [TAPS-1:0][CH_DEPTH-1:0][CH_BITS-1:0]    data;
  logic                                          valid;

  modport m (
    input  reset, clk,
    output rows, cols, row_first, row_last, col_first, col_last, de, user, data, valid
  );

  modport s (
    input  reset, clk,
    input  rows, cols, row_first, row_last, col_first, col_last, de, user, data, valid
  );

endinterface

// File: rtl/img_temporal_diff_stat.sv
// Per-frame motion statistics: thresholded pixel count and |diff| sum, published at frame end.
module img_temporal_diff_stat
  import img_temporal_diff_pkg::*;
#(
  parameter int unsigned CH_BITS    = DEF_CH_BITS,
  parameter int unsigned COUNT_BITS = DEF_COUNT_BITS,
  parameter int unsigned SUM_BITS   = DEF_SUM_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cke,
  input  logic [CH_BITS-1:0]    threshold,
  input  logic [CH_BITS-1:0]    abs_val,
  input  logic                  valid,
  input  logic                  de,
  input  logic                  fs,
  input  logic                  fe,
  output logic [COUNT_BITS-1:0] stat_count,
  output logic [SUM_BITS-1:0]   stat_sum,
  output logic                  stat_valid
);

  logic [CH_BITS-1:0]    thr_q;
  logic                  armed;
  logic [COUNT_BITS-1:0] cnt_q, cnt_d;
  logic [SUM_BITS-1:0]   sum_q, sum_d;
  logic [SUM_BITS:0]     sum_ext;
  logic                  hit;
  logic                  publish;

  always_comb begin
    // The frame-start pixel is compared against the threshold being latched with it.
    hit     = de && (abs_val > (fs ? threshold : thr_q));
    sum_ext = {1'b0, sum_q} + {{(SUM_BITS + 1 - CH_BITS){1'b0}}, abs_val};
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    if (valid) begin
      if (fs) begin
        cnt_d = {{(COUNT_BITS - 1){1'b0}}, hit};
        sum_d = de ? {{(SUM_BITS - CH_BITS){1'b0}}, abs_val} : '0;
      end else if (de) begin
        if (hit && !(&cnt_q))
          cnt_d = cnt_q + COUNT_BITS'(1);
        sum_d = sum_ext[SUM_BITS] ? '1 : sum_ext[SUM_BITS-1:0];
      end
    end
    publish = valid && fe && (armed || fs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q      <= '0;
      armed      <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
      stat_count <= '0;
      stat_sum   <= '0;
      stat_valid <= 1'b0;
    end else if (cke) begin
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      stat_valid <= publish;
      if (valid && fs) begin
        thr_q <= threshold;
        armed <= 1'b1;
      end
      if (publish) begin
        stat_count <= cnt_d;
        stat_sum   <= sum_d;
      end
    end
  end

endmodule

// File: rtl/img_temporal_diff.sv
// Temporal difference (cur - prev, saturated) with 3-stage cke-gated pipeline.
// Statistics are built only when IMG_TEMPORAL_DIFF_STAT_EN is defined.
module img_temporal_diff
  import img_temporal_diff_pkg::*;
#(
  parameter int unsigned CH_BITS    = DEF_CH_BITS,
  parameter int unsigned COUNT_BITS = DEF_COUNT_BITS,
  parameter int unsigned SUM_BITS   = DEF_SUM_BITS,
  parameter int unsigned ROWS_BITS  = 9,
  parameter int unsigned COLS_BITS  = 9,
  parameter int unsigned USER_BITS  = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cke,
  jelly3_mat_if.s               s_mat,
  jelly3_mat_if.m               m_mat,
  input  logic [CH_BITS-1:0]    threshold,
  output logic [COUNT_BITS-1:0] stat_count,
  output logic [SUM_BITS-1:0]   stat_sum,
  output logic                  stat_valid
);

  localparam int unsigned SB_BITS = ROWS_BITS + COLS_BITS + USER_BITS + 5;

  logic [SB_BITS-1:0] sb_in;
  logic [SB_BITS-1:0] s0_sb, s1_sb, s2_sb;
  logic               s0_valid, s1_valid, s2_valid;
  logic [CH_BITS-1:0] s0_cur, s0_prev, s1_cur, s2_cur;
  logic [CH_BITS-1:0] s1_diff, s2_diff, s1_abs;
  longint             d_full, a_full;

  assign sb_in = {s_mat.rows, s_mat.cols, s_mat.row_first, s_mat.row_last,
                  s_mat.col_first, s_mat.col_last, s_mat.de, s_mat.user};

  always_comb begin
    d_full = sat_diff(CH_BITS, longint'(s0_cur), longint'(s0_prev));
    a_full = abs_diff(d_full);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s0_valid <= 1'b0;
      s0_sb    <= '0;
      s0_cur   <= '0;
      s0_prev  <= '0;
      s1_valid <= 1'b0;
      s1_sb    <= '0;
      s1_cur   <= '0;
      s1_diff  <= '0;
      s1_abs   <= '0;
      s2_valid <= 1'b0;
      s2_sb    <= '0;
      s2_cur   <= '0;
      s2_diff  <= '0;
    end else if (cke) begin
      s0_valid <= s_mat.valid;
      s0_sb    <= sb_in;
      s0_cur   <= s_mat.data[0][0];
      s0_prev  <= s_mat.data[0][1];
      s1_valid <= s0_valid;
      s1_sb    <= s0_sb;
      s1_cur   <= s0_cur;
      s1_diff  <= d_full[CH_BITS-1:0];
      s1_abs   <= a_full[CH_BITS-1:0];
      s2_valid <= s1_valid;
      s2_sb    <= s1_sb;
      s2_cur   <= s1_cur;
      s2_diff  <= s1_diff;
    end
  end

  assign {m_mat.rows, m_mat.cols, m_mat.row_first, m_mat.row_last,
          m_mat.col_first, m_mat.col_last, m_mat.de, m_mat.user} = s2_sb;
  assign m_mat.data  = {s2_diff, s2_cur};
  assign m_mat.valid = s2_valid;

`ifdef IMG_TEMPORAL_DIFF_STAT_EN
  // Stat inputs are taken at st1 so the publish register lands with st2 (the FE output beat).
  logic s1_de, s1_fs, s1_fe;
  assign s1_de = s1_sb[USER_BITS];
  assign s1_fe = s1_sb[USER_BITS+3] && s1_sb[USER_BITS+1];
  assign s1_fs = s1_sb[USER_BITS+4] && s1_sb[USER_BITS+2];

  img_temporal_diff_stat #(
    .CH_BITS    (CH_BITS),
    .COUNT_BITS (COUNT_BITS),
    .SUM_BITS   (SUM_BITS)
  ) u_stat (
    .clk        (aclk),
    .rst_n      (aresetn),
    .cke        (cke),
    .threshold  (threshold),
    .abs_val    (s1_abs),
    .valid      (s1_valid),
    .de         (s1_de),
    .fs         (s1_fs),
    .fe         (s1_fe),
    .stat_count (stat_count),
    .stat_sum   (stat_sum),
    .stat_valid (stat_valid)
  );
`else
  assign stat_count = '0;
  assign stat_sum   = '0;
  assign stat_valid = 1'b0;
`endif

endmodule

// File: tb/tb_img_temporal_diff.sv
// Randomized scoreboard bench for img_temporal_diff; expectations follow the build's stat macro.
module tb_img_temporal_diff;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        cke;
  logic [15:0] threshold;
  logic [31:0] stat_count;
  logic [39:0] stat_sum;
  logic        stat_valid;

  always #5 clk = ~clk;

  jelly3_mat_if #(.TAPS(1), .CH_DEPTH(2), .CH_BITS(16), .ROWS_BITS(9), .COLS_BITS(9),
                  .USER_BITS(1)) s_if ();
  jelly3_mat_if #(.TAPS(1), .CH_DEPTH(2), .CH_BITS(16), .ROWS_BITS(9), .COLS_BITS(9),
                  .USER_BITS(1)) m_if ();

  assign s_if.clk   = clk;
  assign s_if.reset = ~aresetn;
  assign m_if.clk   = clk;
  assign m_if.reset = ~aresetn;

  img_temporal_diff #(.CH_BITS(16), .COUNT_BITS(32), .SUM_BITS(40),
                      .ROWS_BITS(9), .COLS_BITS(9), .USER_BITS(1)) dut (
    .aclk       (clk),
    .aresetn    (aresetn),
    .cke        (cke),
    .s_mat      (s_if),
    .m_mat      (m_if),
    .threshold  (threshold),
    .stat_count (stat_count),
    .stat_sum   (stat_sum),
    .stat_valid (stat_valid)
  );

  typedef struct {
    logic [15:0] cur;
    logic [15:0] diff;
    logic [23:0] sb;
    logic        sv;
    logic [31:0] cnt;
    logic [39:0] sum;
    int unsigned at;
  } exp_t;

  exp_t        q[$];
  int unsigned frame_abs[$];
  int unsigned thr_m;
  bit          armed_m;
  int unsigned en_cnt;
  int unsigned n_chk;
  int unsigned n_fail;
  logic        prev_sv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge aresetn)
    if (!aresetn) en_cnt <= 0;
    else if (cke) en_cnt <= en_cnt + 1;

  // Reference model: frame stats from the list of |diff| values gathered since FS.
  task automatic model_push(input logic [15:0] cur, prev, input logic [23:0] sb,
                            input logic rf, rl, cf, cl, de);
    exp_t e;
    int   d;
    int unsigned a;
    d = int'(cur) - int'(prev);
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    a = (d < 0) ? -d : d;
    if (rf && cf) begin
      frame_abs.delete();
      thr_m   = threshold;
      armed_m = 1'b1;
    end
    if (de) frame_abs.push_back(a);
    e.cur  = cur;
    e.diff = 16'(d);
    e.sb   = sb;
    e.sv   = 1'b0;
    e.cnt  = '0;
    e.sum  = '0;
    e.at   = en_cnt;
`ifdef IMG_TEMPORAL_DIFF_STAT_EN
    if (rl && cl && armed_m) begin
      e.sv = 1'b1;
      foreach (frame_abs[i]) begin
        if (frame_abs[i] > thr_m) e.cnt++;
        e.sum += 40'(frame_abs[i]);
      end
    end
`endif
    q.push_back(e);
  endtask

  task automatic send(input logic [15:0] cur, prev, input logic rf, rl, cf, cl, de,
                      input logic [8:0] rows, cols, input bit rand_cke);
    logic [23:0] sb;
    logic        usr;
    bit          acc;
    usr = 1'($urandom);
    sb  = {rows, cols, rf, rl, cf, cl, de, usr};
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      {s_if.rows, s_if.cols, s_if.row_first, s_if.row_last, s_if.col_first,
       s_if.col_last, s_if.de, s_if.user} = sb;
      s_if.data  = {prev, cur};
      s_if.valid = 1'b1;
      cke = (rand_cke && t < 16) ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(posedge clk);
      acc = cke;
      #1;
      if (acc) model_push(cur, prev, sb, rf, rl, cf, cl, de);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_if.valid = 1'b0;
      cke        = 1'b1;
    end
  endtask

  function automatic logic [15:0] rnd_pix();
    int unsigned r;
    r = $urandom_range(0, 3);
    if (r == 0) return 16'h0000;
    if (r == 1) return 16'hffff;
    return 16'($urandom);
  endfunction

  // mode 0: constant cur/prev; mode 1: random values and occasional non-de beats.
  task automatic frame(input int h, w, input int mode, input logic [15:0] c, p,
                       input bit rc, input int chg_at, input logic [15:0] new_thr);
    int idx;
    idx = 0;
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        if (idx == chg_at) threshold = new_thr;
        if (mode == 0)
          send(c, p, r == 0, r == h - 1, k == 0, k == w - 1, 1'b1, 9'(h), 9'(w), rc);
        else
          send(rnd_pix(), rnd_pix(), r == 0, r == h - 1, k == 0, k == w - 1,
               $urandom_range(0, 7) != 0, 9'(h), 9'(w), rc);
        idx++;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      idle(1);
      t++;
    end
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 64'(m_if.valid), 64'd0);
    chk({tag, "_data"}, 64'(m_if.data), 64'd0);
    chk({tag, "_sideband"}, 64'({m_if.rows, m_if.cols, m_if.row_first, m_if.row_last,
        m_if.col_first, m_if.col_last, m_if.de, m_if.user}), 64'd0);
    chk({tag, "_stat_count"}, 64'(stat_count), 64'd0);
    chk({tag, "_stat_sum"}, 64'(stat_sum), 64'd0);
    chk({tag, "_stat_valid"}, 64'(stat_valid), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every enabled output beat.
  initial begin
    bit   en;
    exp_t e;
    prev_sv = 1'b0;
    forever begin
      @(posedge clk);
      en = cke && aresetn;
      #1;
      if (en && m_if.valid) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 64'(m_if.valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("ch0_cur", 64'(m_if.data[0][0]), 64'(e.cur));
          if (e.sb[1]) chk("ch1_diff", 64'(m_if.data[0][1]), 64'(e.diff));
          chk("sideband", 64'({m_if.rows, m_if.cols, m_if.row_first, m_if.row_last,
              m_if.col_first, m_if.col_last, m_if.de, m_if.user}), 64'(e.sb));
          chk("latency", 64'(en_cnt - e.at), 64'd2);
          chk("stat_valid", 64'(stat_valid), 64'(e.sv));
`ifdef IMG_TEMPORAL_DIFF_STAT_EN
          if (e.sv) begin
            chk("stat_count", 64'(stat_count), 64'(e.cnt));
            chk("stat_sum", 64'(stat_sum), 64'(e.sum));
          end
`else
          chk("stat_count_tied", 64'(stat_count), 64'd0);
          chk("stat_sum_tied", 64'(stat_sum), 64'd0);
`endif
        end
      end else if (en) begin
        chk("stat_valid_idle", 64'(stat_valid), 64'd0);
      end else if (aresetn) begin
        chk("stat_valid_hold", 64'(stat_valid), 64'(prev_sv));
      end
      prev_sv = stat_valid;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    armed_m    = 1'b0;
    thr_m      = 0;
    aresetn    = 1'b0;
    cke        = 1'b0;
    threshold  = '0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    {s_if.rows, s_if.cols, s_if.row_first, s_if.row_last, s_if.col_first,
     s_if.col_last, s_if.de, s_if.user} = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    aresetn = 1'b1;
    idle(2);

    // 4x4 constant frame: diff 60, all above 50.
    threshold = 16'd50;
    frame(4, 4, 0, 16'd100, 16'd40, 1'b0, -1, 16'd0);
    idle(4);

    // Saturation at both ends in a 1x2 frame.
    send(16'd0, 16'hffff, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 9'd1, 9'd2, 1'b0);
    send(16'hffff, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 9'd1, 9'd2, 1'b0);
    idle(4);

    // Threshold latched at FS and held despite a mid-frame change.
    threshold = 16'd10;
    frame(2, 4, 0, 16'd520, 16'd500, 1'b0, 4, 16'd1000);
    frame(2, 4, 0, 16'd520, 16'd500, 1'b0, -1, 16'd0);
    idle(4);

    // 1x1 frame: FS and FE on the same pixel.
    threshold = 16'd3;
    send(16'd7, 16'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 9'd1, 9'd1, 1'b0);
    idle(4);

    // FS restart discards the partial frame.
    send(16'd900, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 9'd2, 9'd2, 1'b0);
    frame(2, 2, 0, 16'd30, 16'd20, 1'b0, -1, 16'd0);
    idle(4);

    // Random frames with random cke stalls.
    for (int f = 0; f < 6; f++) begin
      threshold = 16'($urandom_range(0, 40000));
      frame($urandom_range(1, 4), $urandom_range(1, 4), 1, 16'd0, 16'd0, 1'b1, -1, 16'd0);
      if ($urandom_range(0, 1) != 0) idle($urandom_range(0, 3));
    end
    frame(2, 2, 0, 16'd300, 16'd100, 1'b1, -1, 16'd0);
    drain();

    // Reset during the FE cycle drops in-flight beats.
    threshold = 16'd0;
    frame(2, 2, 0, 16'd50, 16'd10, 1'b0, -1, 16'd0);
    @(negedge clk);
    aresetn = 1'b0;
    s_if.valid = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    q.delete();
    frame_abs.delete();
    armed_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("midrst_hold");
    @(negedge clk);
    aresetn = 1'b1;

    // Partial frame (FE without FS) after reset publishes nothing.
    send(16'd60, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9'd2, 9'd2, 1'b0);
    send(16'd60, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 9'd2, 9'd2, 1'b0);
    idle(2);
    threshold = 16'd3;
    frame(2, 2, 0, 16'd15, 16'd10, 1'b0, -1, 16'd0);
    drain();
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
